// File: rtl/bru_bpu_if.sv
// Fetch-lookup and EX-resolution signal bundle between the pipeline and the branch unit/predictor.
interface bru_bpu_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
);
    logic [XLEN-1:0]  f_pc;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_rs1;
    logic [XLEN-1:0]  ex_rs2;
    logic [XLEN-1:0]  ex_imm;
    logic [1:0]       ex_ctrl;
    logic [2:0]       ex_bru_op;
    logic             ex_pred_taken;
    logic [XLEN-1:0]  ex_pred_target;
    logic             ex_taken;
    logic [XLEN-1:0]  ex_target;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] mispredict_cnt;

    modport master (
        output f_pc, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_imm, ex_ctrl, ex_bru_op,
               ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, ex_taken, ex_target, redirect, redirect_pc,
               mispredict_cnt
    );

    modport slave (
        input  f_pc, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_imm, ex_ctrl, ex_bru_op,
               ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, ex_taken, ex_target, redirect, redirect_pc,
               mispredict_cnt
    );
endinterface

// File: rtl/bru_bpu.sv
// Branch resolution unit with a 2-bit-counter BHT and tagged BTB predictor.
// Mispredicts in EX raise a registered one-cycle redirect and bump a saturating counter.
module bru_bpu #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned BHT_IDX = 6,
    parameter int unsigned BTB_IDX = 4,
    parameter int unsigned CNT_W   = 32
) (
    input logic     clk,
    input logic     rst,
    bru_bpu_if.slave bus
);
    localparam int unsigned BHT_N = 1 << BHT_IDX;
    localparam int unsigned BTB_N = 1 << BTB_IDX;
    localparam int unsigned TAG_W = XLEN - BTB_IDX - 2;

    localparam logic [1:0] CTRL_BR   = 2'b00;
    localparam logic [1:0] CTRL_JAL  = 2'b01;
    localparam logic [1:0] CTRL_RSVD = 2'b10;
    localparam logic [1:0] CTRL_JALR = 2'b11;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             is_jump;
        logic [XLEN-1:0]  target;
    } btb_entry_t;

    logic [1:0]  bht_q [BHT_N];
    btb_entry_t  btb_q [BTB_N];

    logic             redirect_q,    redirect_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;

    // Fetch-side lookup
    logic [BHT_IDX-1:0] f_bht_i;
    logic [BTB_IDX-1:0] f_btb_i;
    logic [TAG_W-1:0]   f_tag;
    btb_entry_t         f_ent;
    logic               f_hit;

    assign f_bht_i = bus.f_pc[BHT_IDX+1:2];
    assign f_btb_i = bus.f_pc[BTB_IDX+1:2];
    assign f_tag   = bus.f_pc[XLEN-1:BTB_IDX+2];
    assign f_ent   = btb_q[f_btb_i];
    assign f_hit   = f_ent.valid && (f_ent.tag == f_tag);

    assign bus.pred_taken  = f_hit && (f_ent.is_jump || bht_q[f_bht_i][1]);
    assign bus.pred_target = f_hit ? f_ent.target : bus.f_pc + XLEN'(4);

    // EX-side resolution
    logic [XLEN-1:0] br_sum, jalr_sum, ex_target;
    logic            eq, lt, ltu, cond, ex_taken, is_ctrl, eff_valid, mispredict;

    assign br_sum   = bus.ex_pc + bus.ex_imm;
    assign jalr_sum = bus.ex_rs1 + bus.ex_imm;
    assign eq       = (bus.ex_rs1 == bus.ex_rs2);
    assign lt       = ($signed(bus.ex_rs1) < $signed(bus.ex_rs2));
    assign ltu      = (bus.ex_rs1 < bus.ex_rs2);

    always_comb begin
        cond = 1'b0;
        case (bus.ex_bru_op)
            3'b000:  cond = eq;
            3'b001:  cond = !eq;
            3'b010:  cond = lt;
            3'b011:  cond = !lt;
            3'b110:  cond = ltu;
            3'b111:  cond = !ltu;
            default: cond = 1'b0;
        endcase
    end

    assign is_ctrl   = (bus.ex_ctrl != CTRL_RSVD);
    assign ex_taken  = (bus.ex_ctrl == CTRL_JAL) || (bus.ex_ctrl == CTRL_JALR) ||
                       ((bus.ex_ctrl == CTRL_BR) && cond);
    assign ex_target = (bus.ex_ctrl == CTRL_JALR) ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0})
                                                  : br_sum;

    assign bus.ex_taken  = ex_taken;
    assign bus.ex_target = ex_target;

    // Wrong-path instructions behind an outstanding redirect are ignored
    assign eff_valid  = bus.ex_valid && !redirect_q && is_ctrl;
    assign mispredict = eff_valid && ((ex_taken != bus.ex_pred_taken) ||
                                      (ex_taken && (ex_target != bus.ex_pred_target)));

    always_comb begin
        redirect_d    = mispredict;
        redirect_pc_d = redirect_pc_q;
        cnt_d         = cnt_q;
        if (mispredict) begin
            redirect_pc_d = ex_taken ? ex_target : bus.ex_pc + XLEN'(4);
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Training values
    logic [BHT_IDX-1:0] ex_bht_i;
    logic [BTB_IDX-1:0] ex_btb_i;
    logic [1:0]         bht_cur, bht_d;
    btb_entry_t         btb_d;
    logic               bht_we, btb_we;

    assign ex_bht_i = bus.ex_pc[BHT_IDX+1:2];
    assign ex_btb_i = bus.ex_pc[BTB_IDX+1:2];
    assign bht_cur  = bht_q[ex_bht_i];
    assign bht_we   = eff_valid && (bus.ex_ctrl == CTRL_BR);
    assign btb_we   = eff_valid && ex_taken;

    always_comb begin
        bht_d = bht_cur;
        if (ex_taken && (bht_cur != 2'b11))       bht_d = bht_cur + 2'd1;
        else if (!ex_taken && (bht_cur != 2'b00)) bht_d = bht_cur - 2'd1;
        btb_d.valid   = 1'b1;
        btb_d.tag     = bus.ex_pc[XLEN-1:BTB_IDX+2];
        btb_d.is_jump = (bus.ex_ctrl != CTRL_BR);
        btb_d.target  = ex_target;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
            for (int i = 0; i < BTB_N; i++) btb_q[i] <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            cnt_q         <= '0;
        end else begin
            if (bht_we) bht_q[ex_bht_i] <= bht_d;
            if (btb_we) btb_q[ex_btb_i] <= btb_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.redirect       = redirect_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_bru_bpu.sv
// Randomized and directed bench for bru_bpu against a table-level reference model.
module tb_bru_bpu;
    logic clk = 1'b0;
    logic rst = 1'b1;

    bru_bpu_if #(.XLEN(32), .CNT_W(32)) bus ();

    bru_bpu #(.XLEN(32), .BHT_IDX(6), .BTB_IDX(4), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int unsigned m_bht [64];
    bit          m_bv  [16];
    bit [25:0]   m_tag [16];
    bit          m_bj  [16];
    bit [31:0]   m_bt  [16];
    bit          m_redir;
    bit [31:0]   m_rpc;
    bit [31:0]   m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 1;
        for (int i = 0; i < 16; i++) begin
            m_bv[i] = 0; m_tag[i] = '0; m_bj[i] = 0; m_bt[i] = '0;
        end
        m_redir = 0; m_rpc = '0; m_cnt = '0;
    endfunction

    function automatic void predict(input bit [31:0] pc, output bit tk, output bit [31:0] tg);
        int unsigned bi, hi;
        bit hit;
        bi  = (pc >> 2) % 16;
        hi  = (pc >> 2) % 64;
        hit = m_bv[bi] && (m_tag[bi] == pc[31:6]);
        tk  = hit && (m_bj[bi] || m_bht[hi] >= 2);
        tg  = hit ? m_bt[bi] : pc + 32'd4;
    endfunction

    function automatic void resolve(input bit [1:0] ctrl, input bit [2:0] op,
                                    input bit [31:0] pc, rs1, rs2, imm,
                                    output bit tk, output bit [31:0] tg);
        tk = 0;
        case (ctrl)
            2'd1, 2'd3: tk = 1;
            2'd0: case (op)
                3'd0: tk = (rs1 == rs2);
                3'd1: tk = (rs1 != rs2);
                3'd2: tk = ($signed(rs1) <  $signed(rs2));
                3'd3: tk = ($signed(rs1) >= $signed(rs2));
                3'd6: tk = (rs1 <  rs2);
                3'd7: tk = (rs1 >= rs2);
                default: tk = 0;
            endcase
            default: tk = 0;
        endcase
        tg = (ctrl == 2'd3) ? ((rs1 + imm) & ~32'd1) : pc + imm;
    endfunction

    // One EX cycle: check combinational outputs, clock, update model, check registered outputs
    task automatic exec(input bit v, input bit [1:0] ctrl, input bit [2:0] op,
                        input bit [31:0] pc, rs1, rs2, imm, input bit pt, input bit [31:0] ptg);
        bit et, pk, eff, mis;
        bit [31:0] etg, pkt;
        int unsigned bi, hi;
        bus.ex_valid = v; bus.ex_ctrl = ctrl; bus.ex_bru_op = op; bus.ex_pc = pc;
        bus.ex_rs1 = rs1; bus.ex_rs2 = rs2; bus.ex_imm = imm;
        bus.ex_pred_taken = pt; bus.ex_pred_target = ptg; bus.f_pc = pc;
        #1;
        resolve(ctrl, op, pc, rs1, rs2, imm, et, etg);
        predict(pc, pk, pkt);
        chk("pred_taken_pre", 32'(bus.pred_taken), 32'(pk));
        chk("pred_target_pre", bus.pred_target, pkt);
        chk("ex_taken", 32'(bus.ex_taken), 32'(et));
        chk("ex_target", bus.ex_target, etg);
        eff = v && !m_redir && (ctrl != 2'd2);
        mis = eff && ((et != pt) || (et && etg != ptg));
        bi  = (pc >> 2) % 16;
        hi  = (pc >> 2) % 64;
        @(posedge clk);
        if (eff && ctrl == 2'd0) begin
            if (et && m_bht[hi] < 3) m_bht[hi]++;
            if (!et && m_bht[hi] > 0) m_bht[hi]--;
        end
        if (eff && et) begin
            m_bv[bi] = 1; m_tag[bi] = pc[31:6]; m_bj[bi] = (ctrl != 2'd0); m_bt[bi] = etg;
        end
        m_redir = mis;
        if (mis) begin
            m_rpc = et ? etg : pc + 32'd4;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
        end
        #1;
        chk("redirect", 32'(bus.redirect), 32'(m_redir));
        if (m_redir) chk("redirect_pc", bus.redirect_pc, m_rpc);
        chk("mispredict_cnt", bus.mispredict_cnt, m_cnt);
        predict(pc, pk, pkt);
        chk("pred_taken_post", 32'(bus.pred_taken), 32'(pk));
        chk("pred_target_post", bus.pred_target, pkt);
    endtask

    task automatic idle();
        exec(1'b0, 2'd0, 3'd0, 32'h0000_0F00, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic exec_pred(input bit [1:0] ctrl, input bit [2:0] op,
                             input bit [31:0] pc, rs1, rs2, imm);
        bit pk;
        bit [31:0] pkt;
        predict(pc, pk, pkt);
        exec(1'b1, ctrl, op, pc, rs1, rs2, imm, pk, pkt);
    endtask

    initial begin
        bit pk;
        bit [31:0] pkt, rs1, rs2, imm, pc;
        bus.f_pc = '0; bus.ex_valid = 0; bus.ex_pc = '0; bus.ex_rs1 = '0; bus.ex_rs2 = '0;
        bus.ex_imm = '0; bus.ex_ctrl = '0; bus.ex_bru_op = '0;
        bus.ex_pred_taken = 0; bus.ex_pred_target = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_redirect", 32'(bus.redirect), 32'd0);
        chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
        chk("rst_cnt", bus.mispredict_cnt, 32'd0);
        rst = 1'b0;
        bus.f_pc = 32'h100;
        #1;
        chk("rst_pred_taken", 32'(bus.pred_taken), 32'd0);
        chk("rst_pred_target", bus.pred_target, 32'h104);
        @(posedge clk); #1;

        // beq taken but predicted not-taken
        exec(1'b1, 2'd0, 3'd0, 32'h100, 32'd5, 32'd5, 32'h40, 1'b0, 32'h104);
        chk("beq_redirect", 32'(bus.redirect), 32'd1);
        chk("beq_redirect_pc", bus.redirect_pc, 32'h140);
        chk("beq_cnt", bus.mispredict_cnt, 32'd1);
        chk("beq_pred_taken", 32'(bus.pred_taken), 32'd1);
        chk("beq_pred_target", bus.pred_target, 32'h140);
        idle();
        chk("redirect_one_cycle", 32'(bus.redirect), 32'd0);

        // jalr correctly predicted
        exec(1'b1, 2'd3, 3'd0, 32'h200, 32'h1001, 32'd0, 32'd4, 1'b1, 32'h1004);
        chk("jalr_redirect", 32'(bus.redirect), 32'd0);
        bus.f_pc = 32'h200; #1;
        chk("jalr_btb_taken", 32'(bus.pred_taken), 32'd1);
        chk("jalr_btb_target", bus.pred_target, 32'h1004);

        // Signed vs unsigned compares
        bus.ex_valid = 0; bus.ex_ctrl = 2'd0; bus.ex_rs1 = 32'hFFFF_FFFF; bus.ex_rs2 = 32'd1;
        bus.ex_bru_op = 3'b110; #1;
        chk("bltu_not_taken", 32'(bus.ex_taken), 32'd0);
        bus.ex_bru_op = 3'b010; #1;
        chk("blt_taken", 32'(bus.ex_taken), 32'd1);
        bus.ex_ctrl = 2'd2; #1;
        chk("rsvd_not_taken", 32'(bus.ex_taken), 32'd0);
        @(posedge clk); #1;
        exec_pred(2'd0, 3'b110, 32'h240, 32'hFFFF_FFFF, 32'd1, 32'h10);
        if (m_redir) idle();
        exec_pred(2'd0, 3'b010, 32'h244, 32'hFFFF_FFFF, 32'd1, 32'h10);
        if (m_redir) idle();
        exec(1'b1, 2'd2, 3'd0, 32'h248, '0, '0, 32'h10, 1'b1, 32'h0);
        chk("rsvd_no_redirect", 32'(bus.redirect), 32'd0);

        // BHT saturation and decay
        for (int i = 0; i < 4; i++) begin
            exec_pred(2'd0, 3'd0, 32'h300, 32'd1, 32'd1, 32'h20);
            if (m_redir) idle();
        end
        exec_pred(2'd0, 3'd0, 32'h300, 32'd1, 32'd2, 32'h20);
        if (m_redir) idle();
        bus.f_pc = 32'h300; #1;
        chk("bht_10_still_taken", 32'(bus.pred_taken), 32'd1);
        exec_pred(2'd0, 3'd0, 32'h300, 32'd1, 32'd2, 32'h20);
        if (m_redir) idle();
        bus.f_pc = 32'h300; #1;
        chk("bht_01_not_taken", 32'(bus.pred_taken), 32'd0);

        // Wrong-path kill while redirect is high
        exec(1'b1, 2'd1, 3'd0, 32'h400, '0, '0, 32'h80, 1'b0, 32'h0);
        chk("kill_first_redirect", 32'(bus.redirect), 32'd1);
        exec(1'b1, 2'd1, 3'd0, 32'h500, '0, '0, 32'h80, 1'b0, 32'h0);
        chk("kill_second_no_redirect", 32'(bus.redirect), 32'd0);
        bus.f_pc = 32'h500; #1;
        chk("kill_no_train", 32'(bus.pred_taken), 32'd0);

        // Async reset during redirect
        exec(1'b1, 2'd1, 3'd0, 32'h600, '0, '0, 32'h40, 1'b0, 32'h0);
        chk("pre_rst_redirect", 32'(bus.redirect), 32'd1);
        rst = 1'b1; #1;
        model_reset();
        bus.f_pc = 32'h600; #1;
        chk("async_rst_redirect", 32'(bus.redirect), 32'd0);
        chk("async_rst_cnt", bus.mispredict_cnt, 32'd0);
        chk("async_rst_btb_clear", 32'(bus.pred_taken), 32'd0);
        bus.f_pc = 32'h100; #1;
        chk("async_rst_btb_clear2", 32'(bus.pred_taken), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            bit v, pt;
            bit [31:0] ptg;
            bit [1:0] ctrl;
            bit [2:0] op;
            pc = 32'h1000 | (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 6)
                 | (32'($urandom_range(0, 1)) << 16);
            case ($urandom_range(0, 4))
                0: rs1 = 32'd0;  1: rs1 = 32'd1;  2: rs1 = 32'hFFFF_FFFF;
                3: rs1 = 32'h8000_0000; default: rs1 = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: rs2 = 32'd0;  1: rs2 = 32'd1;  2: rs2 = 32'hFFFF_FFFF;
                3: rs2 = rs1;    default: rs2 = $urandom;
            endcase
            imm  = (32'($urandom_range(0, 63)) << 2) - 32'd128;
            ctrl = 2'($urandom_range(0, 3));
            op   = 3'($urandom_range(0, 7));
            v    = ($urandom_range(0, 9) != 0);
            predict(pc, pk, pkt);
            pt   = ($urandom_range(0, 3) != 0) ? pk : 1'($urandom_range(0, 1));
            ptg  = ($urandom_range(0, 3) != 0) ? pkt : ($urandom & ~32'd3);
            exec(v, ctrl, op, pc, rs1, rs2, imm, pt, ptg);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bru_bpu.md
Name: bru_bpu

Overview:
- Next-generation branch unit: resolves branches and jumps in EX and adds a predictor.
- The predictor is a direct-mapped BHT of 2-bit counters plus a tagged BTB, read by fetch and trained by EX.
- Misprediction is detected in EX and produces a registered one-cycle redirect to fetch.
- Compares are done internally on rs1/rs2, so no external comparator flags are needed; a saturating mispredict counter is kept for performance statistics.

Parameters:
- XLEN, 32, datapath/PC width.
- BHT_IDX, 6, log2 of BHT entries (64).
- BTB_IDX, 4, log2 of BTB entries (16).
- CNT_W, 32, mispredict counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- f_pc  in  XLEN  fetch PC for lookup.
- pred_taken  out  1  fetch prediction (combinational from f_pc).
- pred_target  out  XLEN  predicted target (combinational).
- ex_valid  in  1  EX holds a control-flow instruction.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_rs1  in  XLEN  rs1 operand.
- ex_rs2  in  XLEN  rs2 operand.
- ex_imm  in  XLEN  sign-extended immediate.
- ex_ctrl  in  2  00 branch, 01 jal, 11 jalr, 10 reserved (treated as not-control).
- ex_bru_op  in  3  000 beq, 001 bne, 010 blt, 011 bge, 110 bltu, 111 bgeu; others never taken.
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
- ex_pred_target  in  XLEN  predicted target carried down the pipe.
- ex_taken  out  1  actual outcome (combinational).
- ex_target  out  XLEN  actual target (combinational).
- redirect  out  1  registered one-cycle flush/redirect pulse.
- redirect_pc  out  XLEN  correct next PC, valid while redirect=1.
- mispredict_cnt  out  CNT_W  saturating count of redirects.

Behaviour:
- Reset (async, any cycle, including mid-redirect):
  - all BHT counters = 2'b01 (weakly not-taken);
  - all BTB valid = 0;
  - redirect = 0, redirect_pc = 0, mispredict_cnt = 0.
- Indexing:
  - bht_i = pc[BHT_IDX+1:2];
  - btb_i = pc[BTB_IDX+1:2];
  - BTB tag = pc[XLEN-1:BTB_IDX+2].
- BTB entry fields: valid, tag, is_jump, target.
- Prediction:
  - btb_hit = valid && tag match.
  - pred_taken = btb_hit && (is_jump || bht[bht_i][1]).
  - pred_target = BTB target on hit, else f_pc+4.
  - Tables are read-before-write: a lookup in the same cycle as an update to the same entry returns the pre-update value.
- Resolution (eff_valid = ex_valid && !redirect):
  - Taken condition: jal/jalr always taken; branches use the signed compare for 010/011 and the unsigned compare for 110/111.
  - ex_target = ex_pc+ex_imm for branch/jal; (ex_rs1+ex_imm) with bit0 cleared for jalr.
  - All adds wrap modulo 2^XLEN.
- Mispredict condition: eff_valid && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)).
- On mispredict, next edge:
  - redirect = 1;
  - redirect_pc = ex_taken ? ex_target : ex_pc+4;
  - otherwise redirect = 0.
- Redirect is exactly 1 cycle. While redirect = 1, ex_valid is ignored (wrong-path kill): no training, no new redirect.
- Training on eff_valid, at the clock edge:
  - Branch: bht[bht_i] saturating ±1 (max 11, min 00).
  - Any taken instruction writes its BTB entry: valid=1, tag, target=ex_target, is_jump=(ex_ctrl!=00).
  - A not-taken branch leaves the BTB unchanged.
- mispredict_cnt increments on each mispredict, holds at all-ones.
- ex_ctrl = 10: no training, no redirect, ex_taken = 0.

Test Plan:
- Reset, then f_pc=0x100 → pred_taken=0, pred_target=0x104; mispredict_cnt=0.
- beq at pc=0x100, rs1=rs2=5, imm=0x40, pred_taken=0 → next cycle redirect=1, redirect_pc=0x140, cnt=1; BHT 01→10; BTB valid; f_pc=0x100 then predicts taken, target 0x140.
- jalr at 0x200, rs1=0x1001, imm=4, pred_taken=1, pred_target=0x1004 → ex_target=0x1004, no redirect, BTB entry is_jump=1.
- bltu rs1=0xFFFFFFFF, rs2=1 → not taken; blt with the same operands → taken.
- Four taken updates saturate BHT at 11, then one not-taken → 10, prediction still taken; a further one → 01, not taken.
- Mispredict with ex_valid held high the next cycle → redirect high for exactly 1 cycle, second instruction neither trains nor redirects; rst asserted during redirect → redirect drops asynchronously, BTB cleared.
